// File: rtl/modbus_resp_tx.sv
// rtl/modbus_resp_tx.sv - Modbus RTU response transmitter with RS-485 driver control
module modbus_resp_tx #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 9600,
    parameter int WORD_BYTES    = 2,
    parameter int ADDR_W        = 8,
    parameter int PRE_GAP_BITS  = 10,
    parameter int POST_GAP_BITS = 10,
    parameter int HDR_EN        = 1,
    parameter int CRC_EN        = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    tx_start,
    input  logic [7:0]              slave_id,
    input  logic [7:0]              func_code,
    input  logic [ADDR_W-1:0]       tx_quantity,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    output logic [ADDR_W-1:0]       tx_addr,
    output logic                    busy,
    output logic                    response_done,
    output logic                    rs485_tx,
    output logic                    rs485_tx_en
);
    localparam int BPS      = CLK_FREQ / BAUD_RATE;
    localparam int PRE_CYC  = PRE_GAP_BITS * BPS;
    localparam int POST_CYC = POST_GAP_BITS * BPS;
    localparam int GAP_MAX  = (PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC;
    localparam int CW       = $clog2(((GAP_MAX > BPS) ? GAP_MAX : BPS) + 1);
    localparam int IW       = (ADDR_W + 3 > 8) ? ADDR_W + 3 : 8;
    localparam int WW       = 8 * WORD_BYTES;

    typedef enum logic [2:0] {IDLE, PRE_GAP, NEXT, SEND, POST_GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic              start_r0_q, start_r1_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [9:0]        frame_q, frame_d;
    logic              feed_q, feed_d;
    logic [15:0]       crc_q, crc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        wbyte_q, wbyte_d;
    logic [WW-1:0]     word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] qty_q, qty_d;
    logic [7:0]        slave_q, slave_d;
    logic [7:0]        func_q, func_d;

    logic              start_edge;
    logic              exc;
    logic              fb;
    logic [IW-1:0]     prod, hdr_n, data_n, data_end, total_n;
    logic [7:0]        nbyte;
    logic              nfeed;

    assign start_edge = start_r0_q & ~start_r1_q;
    assign exc        = func_q[7];
    assign prod       = IW'(qty_q) * IW'(WORD_BYTES);
    // Exception frames always carry the 3-byte header-like prefix, never data words
    assign hdr_n      = (exc || HDR_EN != 0) ? IW'(3) : '0;
    assign data_n     = exc ? '0 : prod;
    assign data_end   = hdr_n + data_n;
    assign total_n    = data_end + ((CRC_EN != 0) ? IW'(2) : '0);
    assign fb         = crc_q[0] ^ frame_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        feed_d  = feed_q;
        crc_d   = crc_q;
        idx_d   = idx_q;
        wbyte_d = wbyte_q;
        word_d  = word_q;
        addr_d  = addr_q;
        qty_d   = qty_q;
        slave_d = slave_q;
        func_d  = func_q;
        nbyte   = 8'h00;
        nfeed   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    slave_d = slave_id;
                    func_d  = func_code;
                    qty_d   = tx_quantity;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                    wbyte_d = '0;
                    addr_d  = '0;
                    state_d = PRE_GAP;
                end
            end
            PRE_GAP: begin
                if (int'(cnt_q) + 1 >= PRE_CYC) begin
                    cnt_d   = '0;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (idx_q == total_n) begin
                    cnt_d   = '0;
                    state_d = POST_GAP;
                end else begin
                    if (idx_q < hdr_n) begin
                        nfeed = 1'b1;
                        case (idx_q[1:0])
                            2'd0:    nbyte = slave_q;
                            2'd1:    nbyte = func_q;
                            default: nbyte = exc ? tx_data[7:0] : prod[7:0];
                        endcase
                    end else if (idx_q < data_end) begin
                        nfeed = 1'b1;
                        // First byte of a word snapshots tx_data; later bytes shift out of the copy
                        if (wbyte_q == 2'd0) begin
                            nbyte  = tx_data[WW-1 -: 8];
                            word_d = tx_data << 8;
                        end else begin
                            nbyte  = word_q[WW-1 -: 8];
                            word_d = word_q << 8;
                        end
                        if (wbyte_q == 2'(WORD_BYTES - 1)) begin
                            wbyte_d = '0;
                            if (addr_q != qty_q - 1'b1) begin
                                addr_d = addr_q + 1'b1;
                            end
                        end else begin
                            wbyte_d = wbyte_q + 1'b1;
                        end
                    end else begin
                        nbyte = (idx_q == data_end) ? crc_q[7:0] : crc_q[15:8];
                    end
                    frame_d = {1'b1, nbyte, 1'b0};
                    feed_d  = nfeed;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (int'(cnt_q) + 1 >= BPS) begin
                    cnt_d = '0;
                    // CRC follows the data bits as they leave the line, LSB first
                    if (feed_q && bit_q >= 4'd1 && bit_q <= 4'd8) begin
                        crc_d = {1'b0, crc_q[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
                    end
                    frame_d = {1'b1, frame_q[9:1]};
                    if (bit_q == 4'd9) begin
                        state_d = NEXT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            POST_GAP: begin
                if (int'(cnt_q) + 1 >= POST_CYC) begin
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            start_r0_q <= 1'b0;
            start_r1_q <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '1;
            feed_q     <= 1'b0;
            crc_q      <= '0;
            idx_q      <= '0;
            wbyte_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            qty_q      <= '0;
            slave_q    <= '0;
            func_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_r0_q <= tx_start;
            start_r1_q <= start_r0_q;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            feed_q     <= feed_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            wbyte_q    <= wbyte_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            qty_q      <= qty_d;
            slave_q    <= slave_d;
            func_q     <= func_d;
        end
    end

    assign busy          = (state_q == PRE_GAP) || (state_q == NEXT) ||
                           (state_q == SEND) || (state_q == POST_GAP);
    assign rs485_tx_en   = busy;
    assign response_done = (state_q == DONE);
    assign rs485_tx      = (state_q == SEND) ? frame_q[0] : 1'b1;
    assign tx_addr       = addr_q;

endmodule
